// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and strobes out.
// slave is the receiver's view; master is the view of whatever drives rx and consumes bytes.
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   modport slave (
      input  rx,
      output rx_data,
      output rx_valid,
      output frame_err,
      output busy
   );

   modport master (
      output rx,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal bit timing, mid-bit sampling and framing-error detection.
// A break (line held low past the stop bit) reports one frame_err and then waits for idle.
module uart_rx #(
   parameter int CLK_FREQ = 1_000_000,
   parameter int BAUD     = 9600
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
   localparam logic [31:0] HALF_LAST    = 32'(HALF_BIT - 1);
   localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state, state_next;
   logic        rx_m, rx_s;
   logic [31:0] count, count_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shift, shift_next;
   logic [7:0]  data_hold, data_next;
   logic        valid_pulse, valid_next;
   logic        err_pulse, err_next;
   logic        busy_flag;

   // Two-flop synchronizer; the line idles high so reset loads ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= bus.rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         data_hold   <= '0;
         valid_pulse <= 1'b0;
         err_pulse   <= 1'b0;
         busy_flag   <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         bit_idx     <= bit_idx_next;
         shift       <= shift_next;
         data_hold   <= data_next;
         valid_pulse <= valid_next;
         err_pulse   <= err_next;
         busy_flag   <= (state_next != IDLE);
      end
   end

   // START waits half a bit so every later full-bit wait lands mid-bit.
   always_comb begin
      state_next   = state;
      count_next   = count + 32'd1;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      data_next    = data_hold;
      valid_next   = 1'b0;
      err_next     = 1'b0;
      case (state)
         IDLE: begin
            count_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (count == HALF_LAST) begin
               count_next   = '0;
               bit_idx_next = '0;
               state_next   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (count == BIT_LAST) begin
               count_next   = '0;
               shift_next   = {rx_s, shift[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (count == BIT_LAST) begin
               count_next = '0;
               if (rx_s) begin
                  data_next  = shift;
                  valid_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            count_next = '0;
            if (rx_s) state_next = IDLE;
         end
         default: begin
            count_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign bus.rx_data   = data_hold;
   assign bus.rx_valid  = valid_pulse;
   assign bus.frame_err = err_pulse;
   assign bus.busy      = busy_flag;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx at 10 clocks per bit; a byte queue is the reference model.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   int   ferr_cnt = 0;
   int   overlap_cnt = 0;
   int   last_valid_cycle = -1;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_rx_if bus();

   uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle = cycle + 1;

   // Every cycle a strobe is high becomes one event, so a stretched pulse shows up as an extra event.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_valid) begin
            got_q.push_back(bus.rx_data);
            last_valid_cycle = cycle;
         end
         if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
         if (bus.rx_valid && bus.frame_err) overlap_cnt = overlap_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the first nbits of a frame, bit k ending at round((k+1)*cpb) clocks from the start edge.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input real cpb, input int nbits);
      logic [9:0] bits;
      int t0;
      int bnd;
      bits = {stop_bit, value, 1'b0};
      t0 = cycle;
      for (int k = 0; k < nbits; k++) begin
         bus.rx = bits[k];
         bnd = $rtoi((k + 1) * cpb + 0.5);
         while (cycle - t0 < bnd) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic sendGood(input logic [7:0] value, input real cpb);
      exp_q.push_back(value);
      applyStimulus(value, 1'b1, cpb, 10);
   endtask

   task automatic compareQueues(input string tag);
      checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         checkOutput({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int start_cycle;
      int ferr_before;
      logic saw_busy;
      logic [7:0] r;

      bus.rx = 1'b1;
      rst = 1'b1;
      idleCycles(3);
      checkOutput("reset_data", {24'd0, bus.rx_data}, 32'h00);
      checkOutput("reset_strobes", {30'd0, bus.rx_valid, bus.frame_err}, 32'd0);
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      idleCycles(5);

      // Single frame with latency measured from the start edge
      $display("[TB] single frame A5");
      start_cycle = cycle;
      sendGood(8'hA5, 10.0);
      idleCycles(15);
      checkOutput("single_latency_ok",
                  {31'd0, (last_valid_cycle - start_cycle >= 96) && (last_valid_cycle - start_cycle <= 98)}, 32'd1);
      compareQueues("single");
      checkOutput("single_ferr", ferr_cnt, 0);

      // Asynchronous reset in the middle of a data bit discards the partial byte
      $display("[TB] reset mid-frame");
      applyStimulus(8'h3C, 1'b1, 10.0, 4);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midreset_data", {24'd0, bus.rx_data}, 32'h00);
      checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
      bus.rx = 1'b1;
      idleCycles(3);
      rst = 1'b0;
      idleCycles(5);
      got_q.delete();
      sendGood(8'hA5, 10.0);
      idleCycles(15);
      compareQueues("after_reset");
      checkOutput("after_reset_data", {24'd0, bus.rx_data}, 32'hA5);

      // Back-to-back frames with one-bit stops
      $display("[TB] back-to-back");
      sendGood(8'h00, 10.0);
      sendGood(8'hFF, 10.0);
      sendGood(8'h55, 10.0);
      idleCycles(15);
      compareQueues("b2b");
      checkOutput("b2b_ferr", ferr_cnt, 0);

      // Short low glitch is rejected after the half-bit check
      $display("[TB] glitch");
      saw_busy = 1'b0;
      bus.rx = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.busy) saw_busy = 1'b1;
      end
      bus.rx = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.busy) saw_busy = 1'b1;
      end
      checkOutput("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
      checkOutput("glitch_busy_end", {31'd0, bus.busy}, 32'd0);
      checkOutput("glitch_valid", got_q.size(), 0);
      checkOutput("glitch_ferr", ferr_cnt, 0);

      // Framing error followed by a long break, then a clean frame
      $display("[TB] framing error");
      ferr_before = ferr_cnt;
      applyStimulus(8'h3C, 1'b0, 10.0, 10);
      bus.rx = 1'b0;
      idleCycles(50);
      bus.rx = 1'b1;
      idleCycles(10);
      checkOutput("ferr_count", ferr_cnt - ferr_before, 1);
      checkOutput("ferr_no_valid", got_q.size(), 0);
      checkOutput("ferr_data_kept", {24'd0, bus.rx_data}, 32'h55);
      sendGood(8'h81, 10.0);
      idleCycles(15);
      compareQueues("post_ferr");

      // Transmitter clock skew in both directions with random payloads
      $display("[TB] baud skew");
      ferr_before = ferr_cnt;
      for (int i = 0; i < 20; i++) begin
         r = 8'($urandom_range(0, 255));
         sendGood(r, 9.8);
      end
      idleCycles(15);
      compareQueues("skew_fast");
      for (int i = 0; i < 20; i++) begin
         r = 8'($urandom_range(0, 255));
         sendGood(r, 10.2);
      end
      idleCycles(15);
      compareQueues("skew_slow");
      checkOutput("skew_ferr", ferr_cnt - ferr_before, 0);
      checkOutput("strobe_overlap", overlap_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: LSB-first, 1 start bit, 8 data bits, no parity, 1 stop bit.
- Receive-side counterpart of the UART transmit path.
- Times bits with an internal per-bit counter derived from CLK_FREQ/BAUD, so no external divided clock is needed.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- CLK_FREQ, 1_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in bit/s.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD with integer truncation (104 at defaults). Must be >= 4.
- HALF_BIT (localparam), CLKS_PER_BIT/2 (52 at defaults).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse: rx_data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset: asynchronous, active-high reset rst; clock clk. All registers clear while rst is high:
  - state=IDLE, count=0, bit_idx=0, shift=0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops = 1 (line idle).
- Synchronizer: 2-flop chain rx -> rx_m -> rx_s. All decisions use rx_s only, so there is 2 clocks of input latency.
- Counter: 32-bit count, cleared on every state change and after every sample.
- IDLE: when rx_s==0 -> START, count=0.
- START:
  - count increments each clock.
  - At count==HALF_BIT-1, sample rx_s.
  - rx_s==0 -> DATA, bit_idx=0, count=0.
  - rx_s==1 -> IDLE (glitch rejected). No strobe.
- DATA:
  - At count==CLKS_PER_BIT-1: shift <= {rx_s, shift[7:1]}, count=0, bit_idx++.
  - Sample points sit mid-bit because START ended at mid-start-bit.
  - After the sample with bit_idx==7 -> STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: rx_data<=shift, rx_valid=1 for exactly that cycle, -> IDLE.
  - rx_s==0: frame_err=1 for exactly that cycle, rx_data unchanged, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line (break) produces exactly one frame_err, not repeated frames.
- Strobes: rx_valid and frame_err are never high simultaneously and are never high for more than 1 cycle.
- Back-to-back frames:
  - The cycle after the valid stop sample is IDLE.
  - A start edge already present on rx_s at that point is accepted next cycle.
  - Stop-bit length is therefore effectively 0.5 bit minimum; the receiver is tolerant of transmitters sending a full stop bit.
- busy: registered, equals (state != IDLE). Goes high the cycle after the falling edge is seen on rx_s.
- Reset mid-frame: immediate return to IDLE with outputs cleared. The partial byte is discarded.
- Timing tolerance: total sampling error <= ±1 clk per bit plus truncation of CLKS_PER_BIT. Transmitter baud within ±2% is required.
- Throughput: one byte per 10 bit times; no internal buffering. The consumer must capture rx_data before the next rx_valid, otherwise the previous byte is lost silently.

Test Plan:
Bench uses CLK_FREQ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10, HALF_BIT=5.
- Reset: assert rst mid-idle and mid-DATA -> rx_data=8'h00, all strobes 0, busy 0. After release, a clean frame 8'hA5 is received correctly.
- Single frame 8'hA5:
  - Drive rx bits 0,1,0,1,0,0,1,0,1,1 at 10 clk/bit.
  - Expect exactly one rx_valid pulse with rx_data=8'hA5.
  - The pulse comes 2 (sync) + 5 + 80 + 10 clocks after the start edge, ±1.
  - frame_err stays 0.
- Back-to-back: 8'h00, 8'hFF, 8'h55 with 1-bit stops -> three rx_valid pulses with the matching bytes in order, no frame_err.
- Glitch: rx low for 3 clocks then high -> returns to IDLE, no rx_valid, no frame_err. busy pulses high then low.
- Framing error: frame 8'h3C with stop bit driven 0, then line held low 50 clocks, then high:
  - Exactly one frame_err pulse, no rx_valid, rx_data keeps its prior value.
  - The next clean frame 8'h81 is received.
- Baud skew: transmitter at 9.8 and 10.2 clk/bit (fractional timing in the bench), random bytes x20 -> all bytes match, zero frame_err.
